dmem_bist_master: RTL

Built-in self-test initiator for the single-cycle processor's data memory. It drives the memory's address, write-data and write-enable port, and reads the combinational read-data return. It runs a four-element March test over the full depth, then reports pass/fail and an error count. It sits beside the CPU datapath on the memory port; the top level muxes its A/WD/WE onto the memory while `busy` is high.

---
 rtl/dmem_bist_master.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_bist_master.sv
// dmem_bist_master: four-element March BIST initiator for the single-cycle CPU data memory.
// Define DMEM_BIST_ERR_CAPTURE_EN to add first-mismatch capture ports err_addr / err_data.
module dmem_bist_master #(
   parameter int               WIDTH      = 32,
   parameter int               DEPTH      = 100,
   parameter int               ADDR_BITS  = 32,
   parameter logic [WIDTH-1:0] BG_PATTERN = 32'hA5A5_A5A5
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 start,
   output logic [ADDR_BITS-1:0] A,
   output logic [WIDTH-1:0]     WD,
   output logic                 WE,
   input  logic [WIDTH-1:0]     RD,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [15:0]          err_count
`ifdef DMEM_BIST_ERR_CAPTURE_EN
   ,
   output logic [ADDR_BITS-1:0] err_addr,
   output logic [WIDTH-1:0]     err_data
`endif
);

   typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, FIN} state_t;

   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);
   localparam logic [15:0]          ERR_MAX   = 16'hFFFF;

   state_t                 state_q, state_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic [15:0]            err_count_q, err_count_d;
   logic                   done_q, done_d;
   logic                   pass_q, pass_d;
   logic [WIDTH-1:0]       exp_data;
   logic                   cmp_en;
   logic                   mismatch;
   logic                   elem_end;
`ifdef DMEM_BIST_ERR_CAPTURE_EN
   logic [ADDR_BITS-1:0]   err_addr_q, err_addr_d;
   logic [WIDTH-1:0]       err_data_q, err_data_d;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         err_count_q <= '0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
`ifdef DMEM_BIST_ERR_CAPTURE_EN
         err_addr_q  <= '0;
         err_data_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         err_count_q <= err_count_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
`ifdef DMEM_BIST_ERR_CAPTURE_EN
         err_addr_q  <= err_addr_d;
         err_data_q  <= err_data_d;
`endif
      end
   end

   // M2 walks downward and finishes at 0, so it never decrements past the bottom.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      err_count_d = err_count_q;
      done_d      = done_q;
      pass_d      = pass_q;
      elem_end    = (state_q == M2) ? (addr_q == '0) : (addr_q == LAST_ADDR);
      mismatch    = cmp_en && (RD != exp_data);
`ifdef DMEM_BIST_ERR_CAPTURE_EN
      err_addr_d  = err_addr_q;
      err_data_d  = err_data_q;
      if (mismatch && (err_count_q == '0)) begin
         err_addr_d = addr_q;
         err_data_d = RD;
      end
`endif
      if (mismatch && (err_count_q != ERR_MAX)) begin
         err_count_d = err_count_q + 16'd1;
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = M0;
               addr_d      = '0;
               err_count_d = '0;
               done_d      = 1'b0;
               pass_d      = 1'b0;
`ifdef DMEM_BIST_ERR_CAPTURE_EN
               err_addr_d  = '0;
               err_data_d  = '0;
`endif
            end
         end
         M0: begin
            if (elem_end) begin
               state_d = M1;
               addr_d  = '0;
            end else begin
               addr_d  = addr_q + 1'b1;
            end
         end
         M1: begin
            if (elem_end) begin
               state_d = M2;
               addr_d  = LAST_ADDR;
            end else begin
               addr_d  = addr_q + 1'b1;
            end
         end
         M2: begin
            if (elem_end) begin
               state_d = M3;
               addr_d  = '0;
            end else begin
               addr_d  = addr_q - 1'b1;
            end
         end
         M3: begin
            if (elem_end) begin
               state_d = FIN;
               addr_d  = '0;
            end else begin
               addr_d  = addr_q + 1'b1;
            end
         end
         FIN: begin
            state_d = IDLE;
            done_d  = 1'b1;
            pass_d  = (err_count_q == '0);
         end
         default: state_d = IDLE;
      endcase
   end

   // Port drive is purely a function of the state register, so reset releases the memory at once.
   always_comb begin
      A        = '0;
      WD       = '0;
      WE       = 1'b0;
      busy     = 1'b0;
      cmp_en   = 1'b0;
      exp_data = BG_PATTERN;
      case (state_q)
         M0: begin
            A    = addr_q;
            WD   = BG_PATTERN;
            WE   = 1'b1;
            busy = 1'b1;
         end
         M1: begin
            A        = addr_q;
            WD       = ~BG_PATTERN;
            WE       = 1'b1;
            busy     = 1'b1;
            cmp_en   = 1'b1;
            exp_data = BG_PATTERN;
         end
         M2: begin
            A        = addr_q;
            WD       = BG_PATTERN;
            WE       = 1'b1;
            busy     = 1'b1;
            cmp_en   = 1'b1;
            exp_data = ~BG_PATTERN;
         end
         M3: begin
            A        = addr_q;
            busy     = 1'b1;
            cmp_en   = 1'b1;
            exp_data = BG_PATTERN;
         end
         default: ;
      endcase
   end

   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_count_q;
`ifdef DMEM_BIST_ERR_CAPTURE_EN
   assign err_addr  = err_addr_q;
   assign err_data  = err_data_q;
`endif

endmodule
